// File: rtl/code_lock_pkg.sv
// Shared definitions for the keypad code lock: FSM state encoding, display glyphs
// and the counter-width helper used to size the down-counting timers.
package code_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_REJECT  = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Width of a counter that holds limit-1; never narrower than one bit
    function automatic int cnt_w(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational hex digit to active-low 7-segment decoder ({g..a}).
module seg7_digit
    import code_lock_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (value_i)
            4'h0:    seg_o = 7'b1000000;
            4'h1:    seg_o = 7'b1111001;
            4'h2:    seg_o = 7'b0100100;
            4'h3:    seg_o = 7'b0110000;
            4'h4:    seg_o = 7'b0011001;
            4'h5:    seg_o = 7'b0010010;
            4'h6:    seg_o = 7'b0000010;
            4'h7:    seg_o = 7'b1111000;
            4'h8:    seg_o = 7'b0000000;
            4'h9:    seg_o = 7'b0010000;
            4'hA:    seg_o = 7'b0001000;
            4'hB:    seg_o = 7'b0000011;
            4'hC:    seg_o = 7'b1000110;
            4'hD:    seg_o = 7'b0100001;
            4'hE:    seg_o = 7'b0000110;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/code_lock_ctrl.sv
// Parametrised keypad code lock with inactivity timeout, failed-attempt counter and timed lockout.
// Optional macro CODE_LOCK_AUTORELOCK_EN: OPEN also falls back to IDLE after OPEN_CYC cycles.
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int CODE_LEN    = 3,
    parameter int SYM_W       = 2,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int LOCKOUT_CYC = 500_000_000,
    parameter int OPEN_CYC    = 250_000_000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sym_valid,
    input  logic [SYM_W-1:0]                 sym,
    input  logic [CODE_LEN*SYM_W-1:0]        code,
    input  logic                             relock,
    output logic                             unlocked,
    output logic                             alarm,
    output logic                             busy,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt,
    output logic [6:0]                       seg
);

    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int TW = cnt_w(TIMEOUT_CYC);
    localparam int LW = cnt_w(LOCKOUT_CYC);

    state_e                      state_q, state_d;
    logic [3:0]                  pos_q, pos_d;
    logic [CODE_LEN*SYM_W-1:0]   code_q, code_d;
    logic [FW-1:0]               fail_q, fail_d;
    logic [TW-1:0]               idle_tmr_q, idle_tmr_d;
    logic [LW-1:0]               lock_tmr_q, lock_tmr_d;

    logic [SYM_W-1:0]            exp_sym;
    logic                        last_pos;
    logic                        idle_expired;
    logic                        open_expired;
    logic                        fail_event;
    logic [FW-1:0]               fail_inc;
    logic [6:0]                  pos_seg;

`ifdef CODE_LOCK_AUTORELOCK_EN
    localparam int OW = cnt_w(OPEN_CYC);
    logic [OW-1:0]               open_tmr_q, open_tmr_d;

    assign open_expired = (open_tmr_q == '0);

    always_comb begin
        if (state_q != ST_OPEN)
            open_tmr_d = OW'(OPEN_CYC - 1);
        else if (!open_expired)
            open_tmr_d = open_tmr_q - OW'(1);
        else
            open_tmr_d = open_tmr_q;
    end
`else
    // OPEN never times out in this build (OPEN_CYC is always positive)
    assign open_expired = (OPEN_CYC < 0);
`endif

    always_comb begin
        exp_sym = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (pos_q == 4'(i))
                exp_sym = code_q[i*SYM_W +: SYM_W];
        end
    end

    assign last_pos     = (pos_q == 4'(CODE_LEN - 1));
    assign idle_expired = (idle_tmr_q == '0);
    assign fail_inc     = (fail_q == FW'(MAX_TRIES)) ? fail_q : fail_q + FW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pos_q      <= '0;
            code_q     <= '0;
            fail_q     <= '0;
            idle_tmr_q <= TW'(TIMEOUT_CYC - 1);
            lock_tmr_q <= LW'(LOCKOUT_CYC - 1);
`ifdef CODE_LOCK_AUTORELOCK_EN
            open_tmr_q <= OW'(OPEN_CYC - 1);
`endif
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            code_q     <= code_d;
            fail_q     <= fail_d;
            idle_tmr_q <= idle_tmr_d;
            lock_tmr_q <= lock_tmr_d;
`ifdef CODE_LOCK_AUTORELOCK_EN
            open_tmr_q <= open_tmr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        code_d     = code_q;
        fail_d     = fail_q;
        fail_event = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sym_valid) begin
                    code_d = code;
                    pos_d  = 4'd1;
                    if (sym == code[SYM_W-1:0]) begin
                        if (CODE_LEN == 1) begin
                            state_d = ST_OPEN;
                            fail_d  = '0;
                        end else begin
                            state_d = ST_ENTRY;
                        end
                    end else if (CODE_LEN == 1) begin
                        fail_event = 1'b1;
                    end else begin
                        state_d = ST_REJECT;
                    end
                end
            end
            ST_ENTRY: begin
                // Timeout has priority; a strobe in the expiry cycle is dropped
                if (idle_expired) begin
                    fail_event = 1'b1;
                end else if (sym_valid) begin
                    pos_d = pos_q + 4'd1;
                    if (sym != exp_sym) begin
                        if (last_pos)
                            fail_event = 1'b1;
                        else
                            state_d = ST_REJECT;
                    end else if (last_pos) begin
                        state_d = ST_OPEN;
                        fail_d  = '0;
                    end
                end
            end
            ST_REJECT: begin
                if (idle_expired) begin
                    fail_event = 1'b1;
                end else if (sym_valid) begin
                    pos_d = pos_q + 4'd1;
                    if (last_pos)
                        fail_event = 1'b1;
                end
            end
            ST_OPEN: begin
                if (relock || open_expired)
                    state_d = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (lock_tmr_q == '0) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fail_event) begin
            fail_d  = fail_inc;
            state_d = (fail_inc == FW'(MAX_TRIES)) ? ST_LOCKOUT : ST_IDLE;
        end

        if (state_d != ST_ENTRY && state_d != ST_REJECT)
            pos_d = '0;

        // Timers preload whenever their state is inactive, so entry needs no extra load path
        if ((state_q != ST_ENTRY && state_q != ST_REJECT) || sym_valid)
            idle_tmr_d = TW'(TIMEOUT_CYC - 1);
        else if (!idle_expired)
            idle_tmr_d = idle_tmr_q - TW'(1);
        else
            idle_tmr_d = idle_tmr_q;

        if (state_q != ST_LOCKOUT)
            lock_tmr_d = LW'(LOCKOUT_CYC - 1);
        else if (lock_tmr_q != '0)
            lock_tmr_d = lock_tmr_q - LW'(1);
        else
            lock_tmr_d = lock_tmr_q;
    end

    seg7_digit u_pos_digit (
        .value_i (pos_q),
        .seg_o   (pos_seg)
    );

    always_comb begin
        unlocked = (state_q == ST_OPEN);
        alarm    = (state_q == ST_LOCKOUT);
        busy     = (state_q == ST_ENTRY) || (state_q == ST_REJECT);
        fail_cnt = fail_q;
        case (state_q)
            ST_OPEN:            seg = SEG_P;
            ST_LOCKOUT:         seg = SEG_E;
            ST_ENTRY, ST_REJECT: seg = pos_seg;
            default:            seg = SEG_ZERO;
        endcase
    end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Self-checking bench for code_lock_ctrl: directed scenarios plus random keypresses,
// all compared against a sequence-level reference model.
module tb_code_lock_ctrl;

    localparam int CODE_LEN    = 3;
    localparam int SYM_W       = 2;
    localparam int MAX_TRIES   = 3;
    localparam int TIMEOUT_CYC = 20;
    localparam int LOCKOUT_CYC = 10;
    localparam int OPEN_CYC    = 15;

    localparam int M_IDLE  = 0;
    localparam int M_ENTER = 1;
    localparam int M_OPEN  = 2;
    localparam int M_LOCK  = 3;

    logic       clk;
    logic       reset;
    logic       sym_valid;
    logic [1:0] sym;
    logic [5:0] code;
    logic       relock;
    logic       unlocked;
    logic       alarm;
    logic       busy;
    logic [1:0] fail_cnt;
    logic [6:0] seg;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         m_mode;
    int         m_age;
    int         m_idle;
    int         m_fails;
    logic [1:0] m_code [CODE_LEN];
    logic [1:0] m_keys [$];

    code_lock_ctrl #(
        .CODE_LEN    (CODE_LEN),
        .SYM_W       (SYM_W),
        .MAX_TRIES   (MAX_TRIES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .LOCKOUT_CYC (LOCKOUT_CYC),
        .OPEN_CYC    (OPEN_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sym_valid (sym_valid),
        .sym       (sym),
        .code      (code),
        .relock    (relock),
        .unlocked  (unlocked),
        .alarm     (alarm),
        .busy      (busy),
        .fail_cnt  (fail_cnt),
        .seg       (seg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] digit_glyph(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] model_seg();
        case (m_mode)
            M_ENTER: return digit_glyph(m_keys.size());
            M_OPEN:  return 7'b0001100;
            M_LOCK:  return 7'b0000110;
            default: return 7'b1000000;
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_age   = 0;
        m_idle  = 0;
        m_fails = 0;
        m_keys.delete();
    endtask

    task automatic register_failure();
        if (m_fails < MAX_TRIES)
            m_fails++;
        m_keys.delete();
        m_age = 0;
        m_mode = (m_fails == MAX_TRIES) ? M_LOCK : M_IDLE;
    endtask

    task automatic finish_entry();
        bit all_ok = 1'b1;
        for (int i = 0; i < CODE_LEN; i++)
            if (m_keys[i] != m_code[i]) all_ok = 1'b0;
        if (all_ok) begin
            m_mode  = M_OPEN;
            m_age   = 0;
            m_fails = 0;
            m_keys.delete();
        end else begin
            register_failure();
        end
    endtask

    // One clock edge of the reference model, using the inputs present at that edge
    task automatic model_step(input logic v, input logic [1:0] s, input logic r);
        case (m_mode)
            M_IDLE: begin
                if (v) begin
                    for (int i = 0; i < CODE_LEN; i++)
                        m_code[i] = code[i*SYM_W +: SYM_W];
                    m_keys.delete();
                    m_keys.push_back(s);
                    m_idle = 0;
                    m_mode = M_ENTER;
                    if (m_keys.size() == CODE_LEN) finish_entry();
                end
            end
            M_ENTER: begin
                if (m_idle + 1 == TIMEOUT_CYC) begin
                    register_failure();
                end else if (v) begin
                    m_keys.push_back(s);
                    m_idle = 0;
                    if (m_keys.size() == CODE_LEN) finish_entry();
                end else begin
                    m_idle++;
                end
            end
            M_OPEN: begin
                if (r) begin
                    m_mode = M_IDLE;
`ifdef CODE_LOCK_AUTORELOCK_EN
                end else if (m_age + 1 == OPEN_CYC) begin
                    m_mode = M_IDLE;
`endif
                end else begin
                    m_age++;
                end
            end
            default: begin
                if (m_age + 1 == LOCKOUT_CYC) begin
                    m_mode  = M_IDLE;
                    m_fails = 0;
                end else begin
                    m_age++;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check_eq("unlocked", unlocked, m_mode == M_OPEN);
        check_eq("alarm",    alarm,    m_mode == M_LOCK);
        check_eq("busy",     busy,     m_mode == M_ENTER);
        check_eq("fail_cnt", fail_cnt, m_fails);
        check_eq("seg",      seg,      model_seg());
    endtask

    task automatic tick(input logic v, input logic [1:0] s, input logic r);
        sym_valid = v;
        sym       = s;
        relock    = r;
        @(posedge clk);
        model_step(v, s, r);
        #1;
        compare_all();
        if (v)
            $display("key sym=%0d relock=%0b -> unlocked=%0b alarm=%0b busy=%0b fail_cnt=%0d seg=%07b",
                     s, r, unlocked, alarm, busy, fail_cnt, seg);
        sym_valid = 1'b0;
        relock    = 1'b0;
    endtask

    task automatic enter3(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        tick(1'b1, a, 1'b0);
        tick(1'b1, b, 1'b0);
        tick(1'b1, c, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_unlocked"}, unlocked, 0);
        check_eq({tag, "_alarm"},    alarm,    0);
        check_eq({tag, "_busy"},     busy,     0);
        check_eq({tag, "_fail_cnt"}, fail_cnt, 0);
        check_eq({tag, "_seg"},      seg,      7'b1000000);
    endtask

    initial begin
        int alarm_cycles;
        logic [1:0] key;

        reset     = 1'b1;
        sym_valid = 1'b0;
        sym       = '0;
        relock    = 1'b0;
        code      = 6'b10_01_01;
        model_reset();

        #3 reset = 1'b0;
        #1 check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;

        // Correct code, then relock together with a key
        enter3(2'd1, 2'd1, 2'd2);
        check_eq("open_unlocked", unlocked, 1);
        check_eq("open_seg",      seg,      7'b0001100);
        check_eq("open_fail_cnt", fail_cnt, 0);
        tick(1'b1, 2'd1, 1'b1);
        check_eq("relock_unlocked", unlocked, 0);
        check_eq("relock_seg_pos0", seg,      7'b1000000);

        // Wrong first key still consumes all three symbols
        tick(1'b1, 2'd3, 1'b0);
        check_eq("wrong1_busy", busy, 1);
        check_eq("wrong1_seg",  seg,  7'b1111001);
        tick(1'b1, 2'd1, 1'b0);
        check_eq("wrong2_busy", busy, 1);
        check_eq("wrong2_seg",  seg,  7'b0100100);
        tick(1'b1, 2'd2, 1'b0);
        check_eq("wrong3_busy",     busy,     0);
        check_eq("wrong3_fail_cnt", fail_cnt, 1);
        check_eq("wrong3_unlocked", unlocked, 0);

        // Two more failures -> lockout for exactly LOCKOUT_CYC cycles
        enter3(2'd0, 2'd0, 2'd0);
        check_eq("fail2_cnt", fail_cnt, 2);
        enter3(2'd2, 2'd2, 2'd2);
        check_eq("lock_alarm", alarm, 1);
        alarm_cycles = 0;
        for (int k = 0; k < 30; k++) begin
            if (!alarm) break;
            alarm_cycles++;
            tick(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        check_eq("lock_len",      alarm_cycles, LOCKOUT_CYC);
        check_eq("lock_exit_cnt", fail_cnt,     0);

        // Inactivity timeout
        tick(1'b1, 2'd1, 1'b0);
        for (int k = 0; k < TIMEOUT_CYC - 1; k++) tick(1'b0, 2'd0, 1'b0);
        check_eq("to_pre_busy", busy, 1);
        tick(1'b0, 2'd0, 1'b0);
        check_eq("to_busy",     busy,     0);
        check_eq("to_fail_cnt", fail_cnt, 1);

        // Strobe on the expiry cycle is dropped
        tick(1'b1, 2'd1, 1'b0);
        for (int k = 0; k < TIMEOUT_CYC - 1; k++) tick(1'b0, 2'd0, 1'b0);
        tick(1'b1, 2'd1, 1'b0);
        check_eq("to_drop_busy", busy,     0);
        check_eq("to_drop_cnt",  fail_cnt, 2);

        enter3(2'd1, 2'd1, 2'd2);
        check_eq("reopen_unlocked", unlocked, 1);
        check_eq("reopen_cnt",      fail_cnt, 0);
`ifdef CODE_LOCK_AUTORELOCK_EN
        for (int k = 0; k < OPEN_CYC - 1; k++) tick(1'b1, 2'd0, 1'b0);
        check_eq("auto_pre_unlocked", unlocked, 1);
        tick(1'b0, 2'd0, 1'b0);
        check_eq("auto_unlocked", unlocked, 0);
`else
        for (int k = 0; k < OPEN_CYC + 5; k++) tick(1'b1, 2'd0, 1'b0);
        check_eq("hold_unlocked", unlocked, 1);
        tick(1'b0, 2'd0, 1'b1);
        check_eq("hold_relock", unlocked, 0);
`endif

        // Asynchronous reset in the middle of an entry
        tick(1'b1, 2'd1, 1'b0);
        check_eq("pre_rst_busy", busy, 1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("mid_rst");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        enter3(2'd1, 2'd1, 2'd2);
        check_eq("post_rst_unlocked", unlocked, 1);
        tick(1'b0, 2'd0, 1'b1);

        // Randomised traffic, biased towards correct symbols so all states are reached
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) == 0)
                code = 6'($urandom);
            if ($urandom_range(0, 99) < 3) begin
                int gap = $urandom_range(TIMEOUT_CYC - 3, TIMEOUT_CYC + 3);
                for (int k = 0; k < gap; k++) tick(1'b0, 2'd0, 1'b0);
            end
            if ($urandom_range(0, 1) == 1)
                key = (m_mode == M_ENTER) ? m_code[m_keys.size()] : code[1:0];
            else
                key = 2'($urandom);
            tick(1'($urandom_range(0, 99) < 40), key, 1'($urandom_range(0, 99) < 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
